oflow_mem_history_buffer_mc: RTL and testbench
==============================================

Name: oflow_mem_history_buffer_mc

Overview:
Parametrised successor of the two-lane history memory buffer used by the core FSM.
- Stores the last HIST_DEPTH frames of bbox feature words in a ring of frame slots.
- Accepts NUM_CH words per cycle on write and returns NUM_CH words per line on read.
- Owns its own write/read sequencer, including history-depth clamping and per-lane valid masking.
- Sits between the PE array (write side) and the similarity-metric block (read side); reports progress to the interface.

Parameters:
DATA_WIDTH, 48, width of one bbox feature word
NUM_CH, 2, words per line (lanes), 1..8
HIST_DEPTH, 5, number of frame slots kept (max fallback depth)
MAX_BBOX, 32, max bboxes per frame; slot size in words
BBOX_W, $clog2(MAX_BBOX+1), bbox count width
HIST_W, $clog2(HIST_DEPTH+1), history count width

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous active-low reset
start_write  in  1  pulse: begin storing current frame
data_in_valid  in  1  data_in line valid this cycle (WRITE only)
data_in  in  NUM_CH*DATA_WIDTH  lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
start_read  in  1  pulse: begin streaming history frames
read_new_line  in  1  similarity metric ready for next line
num_of_history_frames  in  HIST_W  requested fallback depth
num_of_bbox_in_frame  in  BBOX_W  bboxes in every frame (sampled at start_*)
busy  out  1  FSM not IDLE
done_write  out  1  one-cycle pulse, frame stored
done_read  out  1  one-cycle pulse, all requested frames streamed
data_out  out  NUM_CH*DATA_WIDTH  read line, registered
data_out_valid  out  1  data_out holds a line this cycle
lane_valid  out  NUM_CH  per-lane valid for data_out
counter_of_history_frame_to_interface  out  HIST_W  index of history frame being read (0 = newest)

Behaviour:
- Reset: all outputs 0; state IDLE; wr_slot=0; valid_frames=0. Memory contents are not reset.
- Reset mid-operation aborts the operation with no done pulse. Stale memory is never read, because valid_frames=0.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE_W, DONE_R.
- IDLE start arbitration:
  - start_write -> WRITE; latch nb=num_of_bbox_in_frame; cnt=0.
  - start_read (and no start_write) -> RD_ISSUE; latch nb; hist=0; cnt=0; nf=min(num_of_history_frames, valid_frames).
  - Simultaneous start_write and start_read: write wins, the read is dropped.
  - start_* while busy: ignored.
- WRITE:
  - Each cycle with data_in_valid, lane k is written to slot wr_slot, entry cnt+k, only if cnt+k<nb. Then cnt+=NUM_CH.
  - When cnt+NUM_CH>=nb on an accepted line -> DONE_W.
  - nb=0: go to DONE_W on the next cycle without waiting for data.
- DONE_W (1 cycle):
  - done_write=1.
  - wr_slot advances; wraps HIST_DEPTH-1 -> 0.
  - valid_frames saturating increment (max HIST_DEPTH).
  - -> IDLE.
- Read slot for history index h: (wr_slot-1-h) mod HIST_DEPTH, i.e. newest stored frame first.
- RD_ISSUE:
  - If hist==nf -> DONE_R. This covers nf=0.
  - If nb=0: hist++ each cycle, no lines issued.
  - Otherwise issue a read of entries cnt..cnt+NUM_CH-1 -> RD_WAIT.
  - The first line of each frame issues without read_new_line.
- Read data timing: data_out, data_out_valid and lane_valid (bit k = cnt+k<nb) are registered and appear the cycle after issue. Masked lanes drive 0.
- RD_WAIT:
  - Wait for a read_new_line pulse (arriving in the same cycle as data_out_valid or later).
  - On the pulse: cnt+=NUM_CH.
  - If cnt>=nb: cnt=0, hist++. counter_of_history_frame_to_interface follows hist.
  - -> RD_ISSUE.
- DONE_R (1 cycle): done_read=1; counter holds last hist; -> IDLE.
- counter_of_history_frame_to_interface clears to 0 on the next start_read.
- Memory: one HIST_DEPTH*MAX_BBOX-entry array per lane; synchronous write; registered read.
- Entry index arithmetic is done at BBOX_W+1 bits so there is no overflow at MAX_BBOX.

Test Plan:
- Reset, then start_read with num_of_history_frames=3 -> nf=0; done_read one cycle after start; no data_out_valid.
- NUM_CH=2, nb=5: write frames A,B (3 lines each) -> done_write after each. Read with depth 3 -> nf=2; B lines then A lines; last line lane_valid=2'b01; counter 0 then 1; done_read.
- Write 7 frames with HIST_DEPTH=5 -> wr_slot wraps to 2, valid_frames=5. Read depth 5 returns frames 6,5,4,3,2 in order.
- start_write and start_read asserted together in IDLE -> write performed, no read lines, busy=1; start_read during WRITE ignored.
- Hold read_new_line low 10 cycles mid-frame -> data_out and data_out_valid hold; no new issue; resumes on pulse.
- Assert reset_N=0 mid-read -> outputs 0 immediately; following read returns done_read with no lines (valid_frames=0).

Source files
------------

// File: rtl/oflow_mem_history_buffer_mc.sv
// ---------------------------------------------------------------------------
// oflow_mem_history_buffer_mc
// History memory for bbox feature words. It keeps the last HIST_DEPTH frames
// in a ring of frame slots, each MAX_BBOX words deep. NUM_CH lanes are written
// and read per line. An internal sequencer handles storing one frame and
// streaming back the requested number of frames, newest first.
//
// Ports
//   clk, reset_N                  clock, asynchronous active-low reset
//   start_write                   pulse: store the incoming frame
//   data_in_valid, data_in        write lines from the PE array
//   start_read                    pulse: stream history frames
//   read_new_line                 consumer ready for the next line
//   num_of_history_frames         requested depth (clamped to frames held)
//   num_of_bbox_in_frame          words per frame, sampled at start_*
//   busy, done_write, done_read   sequencer status
//   data_out, data_out_valid,     registered read line and per-lane valid
//   lane_valid
//   counter_of_history_frame_to_interface  history index being read
// ---------------------------------------------------------------------------
module oflow_mem_history_buffer_mc #(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_CH     = 2,
    parameter int HIST_DEPTH = 5,
    parameter int MAX_BBOX   = 32,
    parameter int BBOX_W     = $clog2(MAX_BBOX + 1),
    parameter int HIST_W     = $clog2(HIST_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset_N,
    input  logic                         start_write,
    input  logic                         data_in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         start_read,
    input  logic                         read_new_line,
    input  logic [HIST_W-1:0]            num_of_history_frames,
    input  logic [BBOX_W-1:0]            num_of_bbox_in_frame,
    output logic                         busy,
    output logic                         done_write,
    output logic                         done_read,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic [NUM_CH-1:0]            lane_valid,
    output logic [HIST_W-1:0]            counter_of_history_frame_to_interface
);

    // Entry counters carry one extra bit so cnt+NUM_CH cannot wrap at MAX_BBOX.
    localparam int CW = BBOX_W + 1;
    localparam int AW = $clog2(HIST_DEPTH * MAX_BBOX);
    localparam logic [CW-1:0] STEP = CW'(NUM_CH);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BBOX);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, DONE_W, DONE_R} state_t;

    state_t                      state_q;
    logic [BBOX_W-1:0]           nb_q;
    logic [CW-1:0]               cnt_q;
    logic [HIST_W-1:0]           hist_q;
    logic [HIST_W-1:0]           nf_q;
    logic [HIST_W-1:0]           wr_slot_q;
    logic [HIST_W-1:0]           valid_frames_q;
    logic                        busy_q;
    logic                        done_write_q;
    logic                        done_read_q;
    logic [NUM_CH*DATA_WIDTH-1:0] data_out_q;
    logic                        data_out_valid_q;
    logic [NUM_CH-1:0]           lane_valid_q;

    logic [DATA_WIDTH-1:0]       mem_q [NUM_CH][HIST_DEPTH*MAX_BBOX];

    logic [CW-1:0]               nb_ext_d;
    logic [CW-1:0]               cnt_inc_d;
    logic [HIST_W-1:0]           rd_slot_d;
    logic [NUM_CH-1:0]           lane_ok_d;
    logic [AW-1:0]               wr_addr_d [NUM_CH];
    logic [AW-1:0]               rd_addr_d [NUM_CH];
    logic                        wr_fire_d;

    function automatic logic [AW-1:0] mem_addr(input logic [HIST_W-1:0] slot,
                                               input logic [CW-1:0]     entry);
        int a;
        a = int'(slot) * MAX_BBOX + int'(entry);
        return AW'(a);
    endfunction

    // Newest stored frame sits one slot behind the write pointer.
    function automatic logic [HIST_W-1:0] read_slot(input logic [HIST_W-1:0] wslot,
                                                    input logic [HIST_W-1:0] h);
        int s;
        s = int'(wslot) + HIST_DEPTH - 1 - int'(h);
        if (s >= HIST_DEPTH) s = s - HIST_DEPTH;
        return HIST_W'(s);
    endfunction

    always_comb begin
        logic [CW-1:0] entry;
        entry     = '0;
        nb_ext_d  = {1'b0, nb_q};
        cnt_inc_d = cnt_q + STEP;
        rd_slot_d = read_slot(wr_slot_q, hist_q);
        wr_fire_d = (state_q == WRITE) && data_in_valid && (nb_q != '0);
        for (int k = 0; k < NUM_CH; k++) begin
            entry        = cnt_q + CW'(k);
            lane_ok_d[k] = (entry < nb_ext_d) && (entry < MAXB);
            wr_addr_d[k] = mem_addr(wr_slot_q, entry);
            rd_addr_d[k] = mem_addr(rd_slot_d, entry);
        end
    end

    // Lane memories: contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_d) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (lane_ok_d[k]) mem_q[k][wr_addr_d[k]] <= data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q          <= IDLE;
            nb_q             <= '0;
            cnt_q            <= '0;
            hist_q           <= '0;
            nf_q             <= '0;
            wr_slot_q        <= '0;
            valid_frames_q   <= '0;
            busy_q           <= 1'b0;
            done_write_q     <= 1'b0;
            done_read_q      <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            lane_valid_q     <= '0;
        end else begin
            done_write_q <= 1'b0;
            done_read_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write has priority; a coincident read request is dropped.
                    if (start_write) begin
                        state_q <= WRITE;
                        nb_q    <= num_of_bbox_in_frame;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (start_read) begin
                        state_q <= RD_ISSUE;
                        nb_q    <= num_of_bbox_in_frame;
                        cnt_q   <= '0;
                        hist_q  <= '0;
                        nf_q    <= (num_of_history_frames < valid_frames_q) ?
                                   num_of_history_frames : valid_frames_q;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (nb_q == '0) begin
                        state_q      <= DONE_W;
                        done_write_q <= 1'b1;
                    end else if (data_in_valid) begin
                        cnt_q <= cnt_inc_d;
                        if (cnt_inc_d >= nb_ext_d) begin
                            state_q      <= DONE_W;
                            done_write_q <= 1'b1;
                        end
                    end
                end
                DONE_W: begin
                    wr_slot_q <= (wr_slot_q == HIST_W'(HIST_DEPTH - 1)) ? '0 : wr_slot_q + HIST_W'(1);
                    if (valid_frames_q != HIST_W'(HIST_DEPTH)) valid_frames_q <= valid_frames_q + HIST_W'(1);
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                RD_ISSUE: begin
                    if (hist_q == nf_q) begin
                        state_q     <= DONE_R;
                        done_read_q <= 1'b1;
                    end else if (nb_q == '0) begin
                        hist_q <= hist_q + HIST_W'(1);
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            data_out_q[k*DATA_WIDTH +: DATA_WIDTH] <=
                                lane_ok_d[k] ? mem_q[k][rd_addr_d[k]] : '0;
                        end
                        data_out_valid_q <= 1'b1;
                        lane_valid_q     <= lane_ok_d;
                        state_q          <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // The line is held until the consumer takes it.
                    if (read_new_line) begin
                        data_out_valid_q <= 1'b0;
                        lane_valid_q     <= '0;
                        if (cnt_inc_d >= nb_ext_d) begin
                            cnt_q  <= '0;
                            hist_q <= hist_q + HIST_W'(1);
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                        state_q <= RD_ISSUE;
                    end
                end
                DONE_R: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy                                  = busy_q;
    assign done_write                            = done_write_q;
    assign done_read                             = done_read_q;
    assign data_out                              = data_out_q;
    assign data_out_valid                        = data_out_valid_q;
    assign lane_valid                            = lane_valid_q;
    assign counter_of_history_frame_to_interface = hist_q;

endmodule

// File: tb/tb_oflow_mem_history_buffer_mc.sv
// ---------------------------------------------------------------------------
// tb_oflow_mem_history_buffer_mc
// Directed bench for the history buffer with NUM_CH=2, HIST_DEPTH=5. Each
// stored word encodes its frame tag and entry index so read-back data can be
// predicted from the frame order alone.
// ---------------------------------------------------------------------------
module tb_oflow_mem_history_buffer_mc;

    logic        clk = 1'b0;
    logic        reset_N = 1'b0;
    logic        start_write = 1'b0;
    logic        data_in_valid = 1'b0;
    logic [95:0] data_in = '0;
    logic        start_read = 1'b0;
    logic        read_new_line = 1'b0;
    logic [2:0]  num_of_history_frames = '0;
    logic [5:0]  num_of_bbox_in_frame = '0;
    logic        busy, done_write, done_read, data_out_valid;
    logic [95:0] data_out;
    logic [1:0]  lane_valid;
    logic [2:0]  hist_cnt;

    int checks = 0;
    int errors = 0;

    oflow_mem_history_buffer_mc #(
        .DATA_WIDTH(48), .NUM_CH(2), .HIST_DEPTH(5), .MAX_BBOX(32)
    ) dut (
        .clk                                   (clk),
        .reset_N                               (reset_N),
        .start_write                           (start_write),
        .data_in_valid                         (data_in_valid),
        .data_in                               (data_in),
        .start_read                            (start_read),
        .read_new_line                         (read_new_line),
        .num_of_history_frames                 (num_of_history_frames),
        .num_of_bbox_in_frame                  (num_of_bbox_in_frame),
        .busy                                  (busy),
        .done_write                            (done_write),
        .done_read                             (done_read),
        .data_out                              (data_out),
        .data_out_valid                        (data_out_valid),
        .lane_valid                            (lane_valid),
        .counter_of_history_frame_to_interface (hist_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] word(input int f, input int e);
        return {16'(f), 16'hC0DE, 16'(e)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input int f, input int nb, input bit both);
        int lines;
        lines = (nb + 1) / 2;
        num_of_bbox_in_frame  = 6'(nb);
        num_of_history_frames = 3'd3;
        start_write = 1'b1;
        start_read  = both;
        step;
        start_write = 1'b0;
        start_read  = 1'b0;
        check("wr_busy", busy, 1);
        if (lines == 0) step;
        for (int l = 0; l < lines; l++) begin
            data_in_valid = 1'b1;
            data_in       = {word(f, 2*l+1), word(f, 2*l)};
            start_read    = both && (l == 0);
            step;
            if (both) check("wr_no_rd_line", data_out_valid, 0);
        end
        data_in_valid = 1'b0;
        start_read    = 1'b0;
        check("wr_done", done_write, 1);
        step;
        check("wr_idle", busy, 0);
    endtask

    task automatic read_frames(input int req, input int nb, input int frames[8],
                               input int exp_nf, input int stall_at);
        int lines_per, li, fi, got;
        logic [1:0]  m;
        logic [47:0] e0, e1;
        bit seen_done;
        lines_per = (nb + 1) / 2;
        li = 0; fi = 0; got = 0; seen_done = 0;
        num_of_history_frames = 3'(req);
        num_of_bbox_in_frame  = 6'(nb);
        start_read = 1'b1;
        step;
        start_read = 1'b0;
        for (int b = 0; b < 400 && !seen_done; b++) begin
            if (done_read) begin
                seen_done = 1;
            end else if (data_out_valid) begin
                m[0] = (2*li   < nb);
                m[1] = (2*li+1 < nb);
                e0 = m[0] ? word(frames[fi % 8], 2*li)   : 48'h0;
                e1 = m[1] ? word(frames[fi % 8], 2*li+1) : 48'h0;
                check("rd_lane_valid", lane_valid, m);
                check("rd_lane0", data_out[47:0], e0);
                check("rd_lane1", data_out[95:48], e1);
                check("rd_hist_cnt", hist_cnt, fi);
                if (got == stall_at) begin
                    for (int s = 0; s < 10; s++) begin
                        step;
                        check("stall_vld", data_out_valid, 1);
                        check("stall_dat", data_out[47:0], e0);
                    end
                end
                got++;
                li++;
                if (li >= lines_per) begin
                    li = 0;
                    fi++;
                end
                read_new_line = 1'b1;
                step;
                read_new_line = 1'b0;
            end else begin
                step;
            end
        end
        check("rd_done_seen", seen_done, 1);
        check("rd_line_count", got, exp_nf * lines_per);
        step;
        check("rd_idle", busy, 0);
    endtask

    initial begin
        int fr[8];
        bit hit;
        step;
        step;
        check("rst_busy", busy, 0);
        check("rst_done_w", done_write, 0);
        check("rst_done_r", done_read, 0);
        check("rst_vld", data_out_valid, 0);
        check("rst_data", data_out[63:0], 0);
        check("rst_lanes", lane_valid, 0);
        check("rst_hist", hist_cnt, 0);
        reset_N = 1'b1;
        step;

        // Empty history: clamp to zero frames.
        fr = '{default: 0};
        read_frames(3, 5, fr, 0, -1);

        // Two frames, read depth 3 clamps to 2, newest first.
        write_frame(10, 5, 0);
        write_frame(11, 5, 0);
        fr = '{11, 10, 0, 0, 0, 0, 0, 0};
        read_frames(3, 5, fr, 2, -1);

        // Simultaneous start: write wins, later read pulse ignored.
        write_frame(12, 5, 1);

        // Fill past depth: seven frames total, ring wraps.
        write_frame(13, 5, 0);
        write_frame(14, 5, 0);
        write_frame(15, 5, 0);
        write_frame(16, 5, 0);
        fr = '{16, 15, 14, 13, 12, 0, 0, 0};
        read_frames(5, 5, fr, 5, 1);

        // Reset in the middle of a read.
        num_of_history_frames = 3'd2;
        num_of_bbox_in_frame  = 6'd5;
        start_read = 1'b1;
        step;
        start_read = 1'b0;
        hit = 0;
        for (int b = 0; b < 20 && !hit; b++) begin
            if (data_out_valid) hit = 1;
            else step;
        end
        check("pre_rst_vld", hit, 1);
        reset_N = 1'b0;
        #1;
        check("mid_rst_vld", data_out_valid, 0);
        check("mid_rst_data", data_out[63:0], 0);
        check("mid_rst_lanes", lane_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hist", hist_cnt, 0);
        step;
        step;
        reset_N = 1'b1;
        step;
        fr = '{default: 0};
        read_frames(3, 5, fr, 0, -1);

        // Zero-bbox frame: write completes without data, read issues no lines.
        write_frame(20, 0, 0);
        read_frames(3, 0, fr, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
